// File: rtl/mem_xbar_pkg.sv
// rtl/mem_xbar_pkg.sv - shared types and helpers for the mem_xbar arbiter
//   host_id_t  : host index wide enough for the largest supported host count
//   rsp_slot_t : one response pipe entry {valid, id, err}
//   in_window(): address window membership test
package mem_xbar_pkg;

  localparam int MaxHosts = 8;
  localparam int HostIdW  = $clog2(MaxHosts);

  typedef logic [HostIdW-1:0] host_id_t;

  typedef struct packed {
    logic     valid;
    host_id_t id;
    logic     err;
  } rsp_slot_t;

  // Window is a power-of-two size aligned to its base, so masking off the
  // offset bits must leave exactly the base.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] start,
                                     input logic [63:0] size);
    return (addr & ~(size - 64'd1)) == start;
  endfunction

endpackage

// File: rtl/mem_xbar_rr_pick.sv
// rtl/mem_xbar_rr_pick.sv - one-hot picker searching upward from a start pointer
//   req    : request vector
//   ptr    : index where the search begins (tie to 0 for fixed priority)
//   onehot : winning request, one-hot
//   idx    : winning index
//   any    : a winner exists
module mem_xbar_rr_pick #(
  parameter int NumHosts = 2,
  parameter int IdxW     = $clog2(NumHosts > 1 ? NumHosts : 2)
) (
  input  logic [NumHosts-1:0] req,
  input  logic [IdxW-1:0]     ptr,
  output logic [NumHosts-1:0] onehot,
  output logic [IdxW-1:0]     idx,
  output logic                any
);

  localparam logic [IdxW:0] Nh = (IdxW+1)'(NumHosts);

  logic [IdxW:0] cand;

  // ptr < NumHosts always holds, so ptr + i < 2*NumHosts and a single
  // conditional subtract is enough to wrap.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < NumHosts; i++) begin
      cand = {1'b0, ptr} + (IdxW+1)'(i);
      if (cand >= Nh) cand = cand - Nh;
      if (!any && req[cand[IdxW-1:0]]) begin
        any                    = 1'b1;
        onehot[cand[IdxW-1:0]] = 1'b1;
        idx                    = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_xbar_arbiter.sv
// rtl/mem_xbar_arbiter.sv - N-host req/gnt/rvalid arbiter in front of a single-port SRAM
//   Optional feature macro: MEM_XBAR_ERR_EN (grant out-of-window requests and answer with err)
//   clk_i, rst_ni                : clock, synchronous active-low reset
//   host_req_i/gnt_o/we_i/be_i/addr_i/wdata_i : per-host request channel
//   host_rvalid_o/err_o          : per-host response, one pulse per grant
//   host_rdata_o                 : read data broadcast to all hosts
//   mem_req_o/we_o/be_o/addr_o/wdata_o : device request channel
//   mem_rvalid_i/rdata_i         : device response
module mem_xbar_arbiter
  import mem_xbar_pkg::*;
#(
  parameter int                   NumHosts   = 2,
  parameter int                   AddrWidth  = 32,
  parameter int                   DataWidth  = 32,
  parameter logic [AddrWidth-1:0] MemStart   = '0,
  parameter int                   MemSize    = 64 * 1024,
  parameter int                   MemLatency = 1,
  parameter bit                   FixedPrio  = 1'b0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumHosts-1:0]                   host_req_i,
  output logic [NumHosts-1:0]                   host_gnt_o,
  input  logic [NumHosts-1:0]                   host_we_i,
  input  logic [NumHosts-1:0][DataWidth/8-1:0]  host_be_i,
  input  logic [NumHosts-1:0][AddrWidth-1:0]    host_addr_i,
  input  logic [NumHosts-1:0][DataWidth-1:0]    host_wdata_i,
  output logic [NumHosts-1:0]                   host_rvalid_o,
  output logic [DataWidth-1:0]                  host_rdata_o,
  output logic [NumHosts-1:0]                   host_err_o,
  output logic                                  mem_req_o,
  output logic                                  mem_we_o,
  output logic [DataWidth/8-1:0]                mem_be_o,
  output logic [AddrWidth-1:0]                  mem_addr_o,
  output logic [DataWidth-1:0]                  mem_wdata_o,
  input  logic                                  mem_rvalid_i,
  input  logic [DataWidth-1:0]                  mem_rdata_i
);

  localparam int              IdxW    = $clog2(NumHosts > 1 ? NumHosts : 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumHosts - 1);

  logic [NumHosts-1:0] in_range;
  logic [NumHosts-1:0] eligible;
  logic [NumHosts-1:0] win_oh;
  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     rr_ptr;
  logic                win_any;
  logic                win_in_range;
  logic                fwd;
  rsp_slot_t           head;
  rsp_slot_t           tail;
  rsp_slot_t           pipe_q [MemLatency];

  always_comb begin
    in_range = '0;
    for (int h = 0; h < NumHosts; h++) begin
      in_range[h] = in_window(64'(host_addr_i[h]), 64'(MemStart), 64'(MemSize));
    end
  end

  // Grants are suppressed while in reset so nothing is forwarded or queued.
`ifdef MEM_XBAR_ERR_EN
  assign eligible = host_req_i & {NumHosts{rst_ni}};
`else
  assign eligible = host_req_i & in_range & {NumHosts{rst_ni}};
`endif

  mem_xbar_rr_pick #(
    .NumHosts (NumHosts),
    .IdxW     (IdxW)
  ) u_pick (
    .req    (eligible),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign host_gnt_o   = win_oh;
  assign win_in_range = in_range[win_idx];
  // An out-of-window winner (only possible with the error feature) takes a
  // grant slot but never reaches the device.
  assign fwd          = win_any & win_in_range;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (fwd) begin
      mem_req_o   = 1'b1;
      mem_we_o    = host_we_i[win_idx];
      mem_be_o    = host_be_i[win_idx];
      mem_addr_o  = host_addr_i[win_idx];
      mem_wdata_o = host_wdata_i[win_idx];
    end
  end

  always_comb begin
    head.valid = win_any;
    head.id    = host_id_t'(win_idx);
`ifdef MEM_XBAR_ERR_EN
    head.err   = win_any & ~win_in_range;
`else
    head.err   = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
      for (int i = 0; i < MemLatency; i++) pipe_q[i] <= '0;
    end else begin
      if (FixedPrio) begin
        rr_ptr <= '0;
      end else if (win_any) begin
        rr_ptr <= (win_idx == LastIdx) ? '0 : win_idx + IdxW'(1);
      end
      pipe_q[0] <= head;
      for (int i = 1; i < MemLatency; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[MemLatency-1];

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int h = 0; h < NumHosts; h++) begin
      host_rvalid_o[h] = tail.valid && (tail.id == host_id_t'(h));
`ifdef MEM_XBAR_ERR_EN
      host_err_o[h]    = tail.valid && tail.err && (tail.id == host_id_t'(h));
`endif
    end
  end

  assign host_rdata_o = (tail.valid && tail.err) ? '0 : mem_rdata_i;

  // A device-bound response leaving the pipe must coincide with device data.
  tail_has_device_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (tail.valid && !tail.err) |-> mem_rvalid_i);

endmodule

// File: tb/tb_mem_xbar_arbiter.sv
// tb/tb_mem_xbar_arbiter.sv - directed bench: round-robin (latency 3) and fixed-priority (latency 1) instances
module tb_mem_xbar_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [1:0]        req, we;
  logic [1:0][3:0]   be;
  logic [1:0][31:0]  addr, wdata;

  logic [1:0]  gnt_a, rv_a, err_a, gnt_b, rv_b, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        mreq_a, mwe_a, mrv_a, mreq_b, mwe_b, mrv_b;
  logic [3:0]  mbe_a, mbe_b;
  logic [31:0] maddr_a, mwd_a, mrd_a, maddr_b, mwd_b, mrd_b;

  int n_cmp = 0;
  int n_bad = 0;

  mem_xbar_arbiter #(.NumHosts(2), .FixedPrio(1'b0), .MemLatency(3)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(req), .host_gnt_o(gnt_a), .host_we_i(we), .host_be_i(be),
    .host_addr_i(addr), .host_wdata_i(wdata), .host_rvalid_o(rv_a),
    .host_rdata_o(rdata_a), .host_err_o(err_a),
    .mem_req_o(mreq_a), .mem_we_o(mwe_a), .mem_be_o(mbe_a), .mem_addr_o(maddr_a),
    .mem_wdata_o(mwd_a), .mem_rvalid_i(mrv_a), .mem_rdata_i(mrd_a)
  );

  mem_xbar_arbiter #(.NumHosts(2), .FixedPrio(1'b1), .MemLatency(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(req), .host_gnt_o(gnt_b), .host_we_i(we), .host_be_i(be),
    .host_addr_i(addr), .host_wdata_i(wdata), .host_rvalid_o(rv_b),
    .host_rdata_o(rdata_b), .host_err_o(err_b),
    .mem_req_o(mreq_b), .mem_we_o(mwe_b), .mem_be_o(mbe_b), .mem_addr_o(maddr_b),
    .mem_wdata_o(mwd_b), .mem_rvalid_i(mrv_b), .mem_rdata_i(mrd_b)
  );

  // Device models: byte-enabled RAM with fixed response latency.
  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  logic [2:0]  vp_a;
  logic [31:0] dp_a [3];
  logic        vp_b;
  logic [31:0] dp_b;

  always @(posedge clk) begin
    if (!rst_n) vp_a <= '0;
    else        vp_a <= {vp_a[1:0], mreq_a};
    dp_a[0] <= ram_a[maddr_a[9:2]];
    dp_a[1] <= dp_a[0];
    dp_a[2] <= dp_a[1];
    if (mreq_a && mwe_a)
      for (int b = 0; b < 4; b++)
        if (mbe_a[b]) ram_a[maddr_a[9:2]][8*b +: 8] <= mwd_a[8*b +: 8];
  end

  always @(posedge clk) begin
    if (!rst_n) vp_b <= 1'b0;
    else        vp_b <= mreq_b;
    dp_b <= ram_b[maddr_b[9:2]];
    if (mreq_b && mwe_b)
      for (int b = 0; b < 4; b++)
        if (mbe_b[b]) ram_b[maddr_b[9:2]][8*b +: 8] <= mwd_b[8*b +: 8];
  end

  assign mrv_a = vp_a[2];
  assign mrd_a = dp_a[2];
  assign mrv_b = vp_b;
  assign mrd_b = dp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    we    = 2'b00;
    be    = '0;
    wdata = '0;
    addr[0] = 32'h100;
    addr[1] = 32'h200;

    // Reset held two cycles with both hosts requesting.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); #1;
      check("rst_gnt_a", 32'(gnt_a), 32'h0);
      check("rst_mreq_a", 32'(mreq_a), 32'h0);
      check("rst_rv_a", 32'(rv_a), 32'h0);
      check("rst_gnt_b", 32'(gnt_b), 32'h0);
      check("rst_rv_b", 32'(rv_b), 32'h0);
    end

    // Contention: round-robin alternates, fixed priority starves h1.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      req   = 2'b11;
      #1;
      check("rr_gnt", 32'(gnt_a), (c % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_maddr", maddr_a, (c % 2 == 0) ? 32'h100 : 32'h200);
      check("rr_mreq", 32'(mreq_a), 32'h1);
      check("rr_rv", 32'(rv_a), (c < 3) ? 32'h0 : (((c - 3) % 2 == 0) ? 32'h1 : 32'h2));
      check("fp_gnt", 32'(gnt_b), 32'h1);
      check("fp_rv", 32'(rv_b), (c < 1) ? 32'h0 : 32'h1);
    end
    for (int c = 6; c < 10; c++) begin
      @(negedge clk);
      req = 2'b00;
      #1;
      check("drain_gnt", 32'(gnt_a), 32'h0);
      check("drain_rv_a", 32'(rv_a), (c < 9) ? (((c - 3) % 2 == 0) ? 32'h1 : 32'h2) : 32'h0);
      check("drain_rv_b", 32'(rv_b), (c == 6) ? 32'h1 : 32'h0);
    end

    // Write: full preload, partial overwrite, read back.
    @(negedge clk);
    req = 2'b10; we = 2'b10; addr[1] = 32'h10; wdata[1] = 32'hCAFEF00D; be[1] = 4'b1111;
    #1;
    check("wr0_gnt", 32'(gnt_a), 32'h2);
    check("wr0_mwe", 32'(mwe_a), 32'h1);
    @(negedge clk);
    wdata[1] = 32'hDEADBEEF; be[1] = 4'b0011;
    #1;
    check("wr1_mbe_a", 32'(mbe_a), 32'h3);
    check("wr1_mwd_a", mwd_a, 32'hDEADBEEF);
    check("wr1_maddr_a", maddr_a, 32'h10);
    check("wr1_mbe_b", 32'(mbe_b), 32'h3);
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr[0] = 32'h10; be[0] = 4'b0000;
    #1;
    check("rd_gnt", 32'(gnt_a), 32'h1);
    check("rd_mwe", 32'(mwe_a), 32'h0);
    check("rd_maddr", maddr_a, 32'h10);
    @(negedge clk);
    req = 2'b00;
    #1;
    check("rd_rv_b", 32'(rv_b), 32'h1);
    check("rd_rdata_b", rdata_b, 32'hCAFEBEEF);
    check("wr0_rv_a", 32'(rv_a), 32'h2);
    @(negedge clk); #1;
    check("wr1_rv_a", 32'(rv_a), 32'h2);
    @(negedge clk); #1;
    check("rd_rv_a", 32'(rv_a), 32'h1);
    check("rd_rdata_a", rdata_a, 32'hCAFEBEEF);

    // Out-of-window request from h0.
    @(negedge clk);
    req = 2'b01; addr[0] = 32'h0001_0000;
    #1;
`ifdef MEM_XBAR_ERR_EN
    check("oor_gnt_a", 32'(gnt_a), 32'h1);
    check("oor_mreq_a", 32'(mreq_a), 32'h0);
    check("oor_gnt_b", 32'(gnt_b), 32'h1);
    check("oor_mreq_b", 32'(mreq_b), 32'h0);
    @(negedge clk);
    req = 2'b00;
    #1;
    check("oor_rv_b", 32'(rv_b), 32'h1);
    check("oor_err_b", 32'(err_b), 32'h1);
    check("oor_rdata_b", rdata_b, 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("oor_rv_a", 32'(rv_a), 32'h1);
    check("oor_err_a", 32'(err_a), 32'h1);
    check("oor_rdata_a", rdata_a, 32'h0);
`else
    check("oor_gnt_a", 32'(gnt_a), 32'h0);
    check("oor_mreq_a", 32'(mreq_a), 32'h0);
    check("oor_gnt_b", 32'(gnt_b), 32'h0);
    @(negedge clk); #1;
    check("oor_stall_a", 32'(gnt_a), 32'h0);
    @(negedge clk);
    req = 2'b00;
    #1;
    @(negedge clk); #1;
    check("oor_rv_a", 32'(rv_a), 32'h0);
    check("oor_err_a", 32'(err_a), 32'h0);
`endif

    // Reset while a latency-3 response is in flight.
    @(negedge clk);
    req = 2'b01; addr[0] = 32'h100;
    #1;
    check("mid_gnt", 32'(gnt_a), 32'h1);
    @(negedge clk);
    req = 2'b00; rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt_a), 32'h0);
    check("mid_rv1", 32'(rv_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rv2", 32'(rv_a), 32'h0);
    @(negedge clk);
    req = 2'b11; addr[1] = 32'h200;
    #1;
    check("mid_rv3", 32'(rv_a), 32'h0);
    check("post_gnt0", 32'(gnt_a), 32'h1);
    @(negedge clk); #1;
    check("post_gnt1", 32'(gnt_a), 32'h2);
    @(negedge clk);
    req = 2'b00;
    #1;
    @(negedge clk); #1;
    check("post_rv0", 32'(rv_a), 32'h1);
    @(negedge clk); #1;
    check("post_rv1", 32'(rv_a), 32'h2);
    @(negedge clk); #1;
    check("post_idle", 32'(rv_a), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
